// File: rtl/noc_pkg.sv
// Shared NoC definitions: router output-port selection and the default link width.
package noc_pkg;

  typedef enum logic [3:0] {
    ALL       = 4'd0,
    NORTH     = 4'd1,
    SOUTH     = 4'd2,
    WEST      = 4'd3,
    EAST      = 4'd4,
    EASTNORTH = 4'd5,
    EASTSOUTH = 4'd6,
    EASTWEST  = 4'd7,
    WESTNORTH = 4'd8,
    WESTSOUTH = 4'd9,
    WESTEAST  = 4'd10
  } router_mode_t;

  localparam int NOC_DATA_WIDTH = 16;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: storage, pointers and occupancy. The caller decides
// when push/pop are legal; this block trusts them.
module sync_fifo_fwft
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  // Storage is not reset; only a push writes it, so data_i is ignored otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so natural pointer rollover is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_port_rx.sv
// Receive endpoint for one router output port: buffers every enabled beat, presents
// it over valid/ready, and counts beats lost to overrun.
module router_port_rx
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = NOC_DATA_WIDTH,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   almost_full_o,
  output logic                   full_o,
  output logic [DROP_WIDTH-1:0]  drop_cnt_o,
  input  logic                   clr_drop_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] head_data;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Handshake: the head entry transfers on any cycle where out_valid_o and
  // out_ready_i are both high; out_valid_o never waits on out_ready_i, and the head
  // stays stable while valid and not accepted. The router side has no backpressure.
  assign pop  = out_valid_o && out_ready_i;
  assign push = enable_i && (!full_o || pop);
  assign drop = enable_i && full_o && !pop;

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (data_i),
    .rd_data (head_data),
    .count   (count_o)
  );

  assign out_valid_o   = (count_o != '0);
  assign out_data_o    = out_valid_o ? head_data : '0;
  assign full_o        = (count_o == DEPTH_C);
  assign almost_full_o = (count_o >= AFULL_C);

  // Clear wins over a same-cycle drop; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_drop_i)                 drop_cnt_o <= '0;
    else if (drop && (drop_cnt_o != '1))   drop_cnt_o <= drop_cnt_o + 1'b1;
  end

endmodule

// File: doc/router_port_rx.md
# router_port_rx

Receive endpoint for one router output port (north/south/west/east `*_data_o` / `*_enable_o`) in the hierarchical mesh NoC. The router port has no backpressure, so this block captures every enabled beat into a small FIFO and presents it to the local consumer (PE scratchpad or GLB bank) over a valid/ready handshake. Beats that arrive while the FIFO is full are dropped and counted, so overruns are visible to software and verification.

## Interface
- `DATA_WIDTH`, 16, payload width; matches router `DATA_WIDTH`.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `AFULL_LEVEL`, 3, occupancy at or above which `almost_full_o` asserts; 1 ≤ value ≤ `DEPTH`.
- `DROP_WIDTH`, 8, width of the saturating drop counter.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `enable_i`  in  1  beat strobe from the router `*_enable_o`.
- `data_i`  in  `DATA_WIDTH`  beat payload from the router `*_data_o`.
- `out_data_o`  out  `DATA_WIDTH`  head-of-FIFO payload.
- `out_valid_o`  out  1  head entry is valid.
- `out_ready_i`  in  1  consumer accepts the head entry.
- `count_o`  out  `$clog2(DEPTH)+1`  current occupancy.
- `almost_full_o`  out  1  `count_o >= AFULL_LEVEL`; upstream uses it to pace injection.
- `full_o`  out  1  `count_o == DEPTH`.
- `drop_cnt_o`  out  `DROP_WIDTH`  number of dropped beats; saturates at all-ones.
- `clr_drop_i`  in  1  synchronously clears `drop_cnt_o`.

## Operation
- push = `enable_i && (!full_o || pop)`; pop = `out_valid_o && out_ready_i`.
- The FIFO is first-word-fall-through: `out_data_o` = `mem[rd_ptr]` while `out_valid_o`, and is forced to 0 when the FIFO is empty.
- `out_valid_o` = `count_o != 0`.
- Push writes `data_i` to `mem[wr_ptr]`; `wr_ptr` increments modulo `DEPTH`. Pop increments `rd_ptr` modulo `DEPTH`.
- Count update: push only gives +1; pop only gives −1; both or neither gives no change.
- Drop: when `enable_i && full_o && !pop`, the beat is discarded and `drop_cnt_o` increments unless it is already all-ones.
- `clr_drop_i` takes priority over a same-cycle drop increment; the result is 0.
- A push into an empty FIFO cannot pop in the same cycle, because `out_valid_o` is still low.
- A push and pop together while full are legal: the beat is accepted, occupancy stays `DEPTH`, and no drop is recorded.
- `data_i` is ignored whenever `enable_i` is low. An X on `data_i` while `enable_i` is low must not propagate.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=0, `count_o`=0, `almost_full_o`=0 (`AFULL_LEVEL` ≥ 1), `full_o`=0, `drop_cnt_o`=0, both pointers = 0. Memory contents are not reset.
- `rst` asserted mid-stream flushes all entries at that edge. Any beat or pop in the same cycle is lost, and it is not counted as a drop.
- Latency: a beat with `enable_i` high sampled at edge N appears on `out_valid_o`/`out_data_o` after edge N, i.e. in cycle N+1.
- Pop: with `out_ready_i` high at edge N, the next entry (or valid=0) is presented after edge N.
- Throughput: one push and one pop per cycle sustained, with no bubbles.
- `full_o`, `almost_full_o` and `count_o` are registered-state functions with no combinational path from `enable_i`.
- `out_ready_i` affects only push acceptance when full. It has no combinational path to any output.

## Structure
- Shared package `noc_pkg`:
  - `router_mode_t` enum: ALL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4, EASTNORTH=5, EASTSOUTH=6, EASTWEST=7, WESTNORTH=8, WESTSOUTH=9, WESTEAST=10.
  - Default `NOC_DATA_WIDTH` = 16.
  - This block does not use the enum directly, but benches drive the router with it.
- One sub-module, `sync_fifo_fwft`: storage, pointers and count, parameterised by `DATA_WIDTH` and `DEPTH`.
- Drop counter, almost-full compare and output masking live in `router_port_rx`.

## Test plan
- **Basic latency:** reset, then one beat `data_i`=0x00A5 with `out_ready_i`=1 → `out_valid_o`=1 and `out_data_o`=0x00A5 exactly one cycle later, then valid=0; `drop_cnt_o`=0.
- **Fill and overrun:** `out_ready_i`=0, 6 consecutive beats 0..5, DEPTH=4 → `count_o` 1,2,3,4; `almost_full_o` rises at count 3; `full_o` at 4; `drop_cnt_o`=2. Draining then yields 0,1,2,3 in order.
- **Full with simultaneous push/pop:** full with 0..3, then beat 0x10 with `out_ready_i`=1 → 0 is popped, 0x10 is accepted, `count_o` stays 4, no drop. Drain order is 1,2,3,0x10.
- **Sustained stream and pointer wrap:** 20 back-to-back beats 0..19 with `out_ready_i`=1 → output 0..19 in order, each one cycle after its input; `count_o` ≤ 1.
- **Saturation and clear:** DROP_WIDTH=2, FIFO full, 5 extra beats → `drop_cnt_o` sticks at 3. Pulse `clr_drop_i` together with a drop → 0.
- **Reset mid-stream:** 3 entries queued, `rst` high for one cycle while `enable_i`=1 → all outputs at reset values the next cycle. The following beat 0x0077 emerges alone.
